// File: rtl/byte_bus_arbiter_pkg.sv
// Shared definitions for the two-requester byte bus arbiter: state encodings,
// bus width and the round-robin pick helper.
package byte_bus_arbiter_pkg;

  localparam int unsigned BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  // Returns {any_winner, winner}; on a tie the requester other than ptr wins.
  function automatic logic [1:0] arb_pick(input logic r0, input logic r1, input logic ptr);
    logic [1:0] res;
    res = 2'b00;
    if (r0 && r1) begin
      res = {1'b1, ~ptr};
    end else if (r0) begin
      res = 2'b10;
    end else if (r1) begin
      res = 2'b11;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux2_1byte.sv
// Plain 2:1 byte multiplexer used for the shared bus data path.
module mux2_1byte #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/byte_bus_arbiter.sv
// Round-robin arbiter sharing one byte bus between two requesters, with burst
// hold and an optional per-grant beat limit.
module byte_bus_arbiter
  import byte_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned DATA_W    = BUS_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              last0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  input  logic              last1,
  input  logic              bus_ready,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid
);

  localparam logic [8:0] LIMIT = 9'(MAX_BURST);

  arb_state_t state_q, state_d;
  logic       sel_q, sel_d;
  logic       ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       beat;
  logic       at_limit;
  logic       rearb;
  logic       r0, r1;
  logic [1:0] pick;

  assign gnt0      = (state_q == OWN0);
  assign gnt1      = (state_q == OWN1);
  assign sel       = sel_q;
  assign bus_valid = (gnt0 & req0) | (gnt1 & req1);
  assign beat      = bus_valid & bus_ready;
  assign at_limit  = (LIMIT != '0) && (({1'b0, cnt_q} + 9'd1) == LIMIT);

  mux2_1byte #(
    .W(DATA_W)
  ) u_mux (
    .d0 (data0),
    .d1 (data1),
    .sel(sel_q),
    .y  (bus_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Release re-runs arbitration in the same cycle so handover has no IDLE bubble;
  // a finished or withdrawn owner is masked out, a limit-hit owner is not.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rearb   = 1'b0;
    r0      = req0;
    r1      = req1;
    case (state_q)
      IDLE: rearb = 1'b1;
      OWN0: begin
        if (!req0 || (beat && last0)) begin
          rearb = 1'b1;
          r0    = 1'b0;
        end else if (beat && at_limit) begin
          rearb = 1'b1;
        end else if (beat && (cnt_q != 8'hFF)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      OWN1: begin
        if (!req1 || (beat && last1)) begin
          rearb = 1'b1;
          r1    = 1'b0;
        end else if (beat && at_limit) begin
          rearb = 1'b1;
        end else if (beat && (cnt_q != 8'hFF)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    pick = arb_pick(r0, r1, ptr_q);
    if (rearb) begin
      if (pick[1]) begin
        state_d = pick[0] ? OWN1 : OWN0;
        sel_d   = pick[0];
        ptr_d   = pick[0];
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

endmodule
